// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with configurable wait states,
// byte/halfword/word writes and a two-cycle ERROR response.
//
// Ports:
//   hclk, hresetn           clock, async active-low reset
//   hsel, haddr, htrans,    address phase from master/decoder
//   hwrite, hsize
//   hwdata                  write data, valid in data phase
//   hready                  bus-wide ready from the response mux
//   hrdata, hreadyout,      slave response
//   hresp
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic                  active_q, active_d;
    logic [31:0]           mem_q [DEPTH];

    logic                  accept;
    logic                  addr_err;
    logic                  complete;
    logic                  we;
    logic [3:0]            be;
    logic [ADDR_WIDTH-3:0] widx;
    logic                  unused;

    assign unused = ^{haddr[31:ADDR_WIDTH], htrans[0]};

    assign accept = hsel && hready && htrans[1];

    always_comb begin
        addr_err = 1'b0;
        unique case (1'b1)
            (hsize > 3'd2):                          addr_err = 1'b1;
            (hsize == 3'd1):                         addr_err = haddr[0];
            (hsize == 3'd2):                         addr_err = |haddr[1:0];
            default:                                 addr_err = 1'b0;
        endcase
    end

    // active_q marks an OKAY data phase in flight; it completes in the
    // first IDLE cycle that follows its acceptance (directly or after WAIT).
    assign complete = (state_q == S_IDLE) && active_q;
    assign we       = complete && write_q;
    assign widx     = addr_q[ADDR_WIDTH-1:2];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        active_d = active_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE and ERR2 both present hreadyout=1 and take new transfers
                state_d = S_IDLE;
                if (hready) begin
                    active_d = accept && !addr_err;
                end
                if (accept) begin
                    addr_d  = haddr[ADDR_WIDTH-1:0];
                    write_d = hwrite;
                    size_d  = hsize;
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        unique case (state_q)
            S_WAIT: hreadyout = 1'b0;
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            S_ERR2: hresp = 1'b1;
            default: hreadyout = 1'b1;
        endcase
        hrdata = (complete && !write_q) ? mem_q[widx] : '0;
    end

    always_comb begin
        be = 4'b0000;
        unique case (size_q)
            3'd0:    be[addr_q[1:0]] = 1'b1;
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Memory is deliberately not reset; an async reset clears active_q,
    // so a write still in its data phase is dropped.
    always_ff @(posedge hclk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with 0, 2 and 3
// wait states, each driven by its own random + directed stimulus.
module tb_ahb_sram_slave;

    localparam int AW = 10;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    int total = 0;
    int bad   = 0;
    int ndone = 0;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;

        logic        rst_n  = 1'b0;
        logic        hsel   = 1'b0;
        logic        hwrite = 1'b0;
        logic        stall  = 1'b0;
        logic [31:0] haddr  = '0;
        logic [31:0] hwdata = '0;
        logic [1:0]  htrans = '0;
        logic [2:0]  hsize  = '0;
        logic        hready, hreadyout, hresp;
        logic [31:0] hrdata;

        exp_t        q[$];
        logic [31:0] mdl [256];
        bit          in_dp = 1'b0;
        int          lows  = 0;

        // stall emulates another slave's data phase holding hready low
        assign hready = hreadyout && !stall;

        ahb_sram_slave #(
            .ADDR_WIDTH (AW),
            .WAIT_STATES(WS)
        ) u_dut (
            .hclk     (hclk),
            .hresetn  (rst_n),
            .hsel     (hsel),
            .haddr    (haddr),
            .htrans   (htrans),
            .hwrite   (hwrite),
            .hsize    (hsize),
            .hwdata   (hwdata),
            .hready   (hready),
            .hrdata   (hrdata),
            .hreadyout(hreadyout),
            .hresp    (hresp)
        );

        task automatic ck(input string nm, input logic [31:0] act,
                          input logic [31:0] req);
            chk($sformatf("d%0d.%s", g, nm), act, req);
        endtask

        always @(negedge hclk) begin
            exp_t e;
            if (!rst_n) begin
                in_dp = 1'b0;
                lows  = 0;
            end else begin
                if (in_dp) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL d%0d.sb_empty: got 0 want 1", g);
                        in_dp = 1'b0;
                    end else if (!hreadyout) begin
                        lows++;
                        ck("stall_resp", 32'(hresp), 32'(q[0].err));
                        if (lows > 16) begin
                            total++;
                            bad++;
                            $display("FAIL d%0d.stuck: got %0d want <=16", g, lows);
                            void'(q.pop_front());
                            in_dp = 1'b0;
                            lows  = 0;
                        end
                    end else begin
                        e = q.pop_front();
                        ck("low_cycles", 32'(lows), e.err ? 32'd1 : 32'(WS));
                        ck("hresp", 32'(hresp), 32'(e.err));
                        ck("hrdata", hrdata, (e.rd && !e.err) ? e.data : 32'd0);
                        lows  = 0;
                        in_dp = 1'b0;
                    end
                end else begin
                    ck("idle_rdy", 32'(hreadyout), 32'd1);
                    ck("idle_resp", 32'(hresp), 32'd0);
                    ck("idle_rdata", hrdata, 32'd0);
                end
                if (!in_dp && hsel && hready && htrans[1]) in_dp = 1'b1;
            end
        end

        task automatic issue(input bit wr, input logic [31:0] addr,
                             input logic [2:0] sz, input logic [31:0] wd,
                             input bit commit = 1'b1);
            exp_t e;
            int   n   = 0;
            int   idx = int'(addr[AW-1:2]);
            int   lo  = int'(addr[1:0]);
            int   nb  = 1 << int'(sz);
            e.err  = (sz > 3'd2) || ((lo % nb) != 0);
            e.rd   = !wr;
            e.data = mdl[idx];
            if (wr && !e.err && commit) begin
                for (int b = lo; b < lo + nb; b++) begin
                    mdl[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end
            hsel   = 1'b1;
            htrans = {1'b1, 1'($urandom_range(0, 1))};
            haddr  = addr;
            hwrite = wr;
            hsize  = sz;
            do begin
                @(negedge hclk);
                n++;
            end while (!hready && n < 64);
            if (!hready) begin
                total++;
                bad++;
                $display("FAIL d%0d.accept_timeout: got 0 want 1", g);
            end
            q.push_back(e);
            @(posedge hclk);
            #1;
            hwdata = wr ? wd : $urandom;
            hsel   = 1'b0;
            htrans = 2'b00;
        endtask

        task automatic drain();
            int n = 0;
            hsel   = 1'b0;
            htrans = 2'b00;
            do begin
                @(negedge hclk);
                n++;
            end while (!hreadyout && n < 64);
            @(posedge hclk);
            #1;
        endtask

        task automatic junk(input int kind);
            if (kind == 0) begin
                drain();
                stall = 1'b1;
            end
            hsel   = (kind != 2);
            htrans = (kind == 1) ? 2'($urandom_range(0, 1)) : 2'b10;
            haddr  = $urandom;
            hwrite = 1'($urandom_range(0, 1));
            hsize  = 3'($urandom_range(0, 2));
            @(posedge hclk);
            #1;
            stall  = 1'b0;
            hsel   = 1'b0;
            htrans = 2'b00;
        endtask

        task automatic mid_reset(input logic [31:0] addr);
            issue(1'b1, addr, 3'd2, 32'h0000_0055, 1'b0);
            @(negedge hclk);
            #1;
            rst_n = 1'b0;
            #1;
            ck("midrst_rdy", 32'(hreadyout), 32'd1);
            ck("midrst_resp", 32'(hresp), 32'd0);
            ck("midrst_rdata", hrdata, 32'd0);
            q.delete();
            repeat (2) @(posedge hclk);
            #1;
            rst_n = 1'b1;
            @(posedge hclk);
            #1;
        endtask

        initial begin
            logic [2:0] sz;
            int         k;
            repeat (3) @(posedge hclk);
            #1;
            rst_n = 1'b1;
            @(negedge hclk);
            ck("rst_rdy", 32'(hreadyout), 32'd1);
            ck("rst_resp", 32'(hresp), 32'd0);
            ck("rst_rdata", hrdata, 32'd0);
            @(posedge hclk);
            #1;
            for (int i = 0; i < 256; i++) issue(1'b1, 32'(i * 4), 3'd2, $urandom);

            issue(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
            issue(1'b0, 32'h10, 3'd2, 32'h0);
            issue(1'b1, 32'h20, 3'd2, 32'h0);
            issue(1'b1, 32'h22, 3'd0, 32'h00AB_0000);
            issue(1'b1, 32'h20, 3'd1, 32'h0000_1234);
            issue(1'b0, 32'h20, 3'd2, 32'h0);
            drain();
            issue(1'b0, 32'h10, 3'd2, 32'h0);
            issue(1'b0, 32'h20, 3'd2, 32'h0);
            issue(1'b1, 32'h11, 3'd2, 32'hFFFF_FFFF);
            issue(1'b0, 32'h00, 3'd3, 32'h0);
            issue(1'b1, 32'h13, 3'd1, 32'hFFFF_FFFF);
            issue(1'b1, 32'h10, 3'd3, 32'hFFFF_FFFF);
            issue(1'b0, 32'h10, 3'd2, 32'h0);
            drain();
            mid_reset(32'h30);
            issue(1'b0, 32'h30, 3'd2, 32'h0);

            for (int i = 0; i < 400; i++) begin
                k = $urandom_range(0, 11);
                if (k < 3) begin
                    junk(k);
                end else begin
                    sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                     : 3'($urandom_range(0, 2));
                    issue(1'($urandom_range(0, 1)), $urandom, sz, $urandom);
                end
            end
            drain();
            repeat (2) @(posedge hclk);
            ndone++;
        end
    end

    initial begin
        fork
            wait (ndone == 3);
            #500000;
        join_any
        disable fork;
        if (ndone != 3) begin
            total++;
            bad++;
            $display("FAIL global_timeout: got %0d want 3", ndone);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite single-port SRAM slave; one instance per slave slot, directly upstream of the slave-response mux.
- Its hrdata/hreadyout/hresp are one of the four response sets the mux selects between.
- Adds configurable wait states, byte/halfword/word writes and a two-cycle ERROR response, so the mux and decoder see realistic stalled and errored transfers.

Parameters:
- ADDR_WIDTH, 10: byte-address bits decoded. Memory is 2^(ADDR_WIDTH-2) 32-bit words; haddr above bit ADDR_WIDTH-1 is ignored.
- WAIT_STATES, 0: number of hreadyout-low cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- hclk       in   1   clock; all state on rising edge
- hresetn    in   1   asynchronous active-low reset
- hsel       in   1   slave select from decoder
- haddr      in   32  byte address
- htrans     in   2   transfer type; bit 1 set = NONSEQ/SEQ
- hwrite     in   1   1 = write
- hsize      in   3   0 = byte, 1 = halfword, 2 = word
- hwdata     in   32  write data, valid in data phase
- hready     in   1   bus-wide ready, returned from the mux
- hrdata     out  32  read data
- hreadyout  out  1   slave ready
- hresp      out  1   0 = OKAY, 1 = ERROR

Behaviour:
Reset:
- hresetn low gives hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter 0 and all captured address-phase registers cleared.
- Memory contents are not reset.
- Reset asserted mid-transfer aborts it immediately; a pending write is not committed.

Address phase:
- A transfer is accepted on a rising edge where hsel=1, hready=1 and htrans[1]=1.
- On acceptance, capture haddr[ADDR_WIDTH-1:0], hwrite and hsize.
- IDLE/BUSY, or hsel=0 with hready=1, moves the FSM to IDLE and produces no data phase.

Error check at acceptance:
- A transfer is errored if hsize>2, or hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0.

FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE: hreadyout=1, hresp=0.
  - Errored accept goes to ERR1.
  - OKAY accept with WAIT_STATES>0 goes to WAIT and loads the counter with WAIT_STATES.
  - OKAY accept with WAIT_STATES=0 completes its data phase in the next cycle, with the FSM still in IDLE.
- WAIT: hreadyout=0, hresp=0; counter decrements each cycle. Leaving WAIT, the next cycle is the completion cycle (hreadyout=1).
- ERR1: hreadyout=0, hresp=1; always goes to ERR2.
- ERR2: hreadyout=1, hresp=1. A new transfer may be accepted in this same cycle, following the normal acceptance rule.

Data phase completion (hreadyout=1 cycle of an OKAY transfer):
- Read: hrdata = mem[addr_q[ADDR_WIDTH-1:2]], a combinational read of the full 32-bit word. hrdata=0 in every other cycle.
- Write: byte lanes committed at the rising edge ending the completion cycle, taken from hwdata at the matching lanes:
  - byte: lane addr_q[1:0]
  - halfword: lanes {addr_q[1],0} and {addr_q[1],1}
  - word: all four lanes
- Errored transfers never write memory and drive hrdata=0.

Pipelining and ordering:
- A new address phase may be accepted in the same cycle a data phase completes (back-to-back, zero dead cycles).
- While hreadyout=0, hready is low bus-wide, so no new accept occurs.
- A write followed immediately by a read of the same word returns the new data; no forwarding path is needed because the write commits before the read's data phase.
- Address-phase signals arriving while another slave's data phase stalls (hready=0) are ignored.

Test Plan:
- Reset: hold hresetn=0 for 3 cycles, release -> hreadyout=1, hresp=0, hrdata=0.
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then word read @0x10 back-to-back -> read completion cycle has hrdata=0xDEADBEEF and hreadyout=1 in the cycle after the read address phase.
- Byte lanes: word write 0x00000000 @0x20, byte write 0xAB @0x22 (hwdata=0x00AB0000), halfword write 0x1234 @0x20 -> word read @0x20 = 0x00AB1234.
- WAIT_STATES=2: read @0x10 -> hreadyout low for exactly 2 cycles, then high with data; next transfer accepted on that completion edge.
- Errors: word access @0x11, then hsize=3 @0x00 -> each gives hreadyout=0/hresp=1, then hreadyout=1/hresp=1; memory @0x10 unchanged.
- Reset mid-wait: WAIT_STATES=3 write 0x55 @0x30, assert hresetn during WAIT -> outputs return to reset values at once; a later read @0x30 returns its prior contents.
